routex_port_arbiter: RTL
========================

Name: routex_port_arbiter

Overview:
- Per-output-port frame arbiter that sits in front of routex_mux.
- Watches every input port's destination/SOF/EOF sideband and grants exactly one input port the output port PortNo for a whole frame (SOF to EOF).
- Round-robin fairness between requesters; losers get backpressure and a collision flag.
- Drives routex_mux select and the per-input D_BP; releases on EOF, timeout or abort.

Parameters:
- Numports, 4: number of input ports.
- PortNo, 1: output port index this arbiter owns (compared against DEST).
- TimeoutW, 16: width of the idle-beat watchdog counter.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- DEST  in  [Numports-1:0][7:0]  destination port per input
- DEST_VALID  in  [Numports-1:0]  DEST qualifier; held high for the whole frame
- D_SOF  in  [Numports-1:0]  start-of-frame pulse
- D_EOF  in  [Numports-1:0]  end-of-frame, qualified by a beat
- D_HDR_VALID  in  [Numports-1:0]  header beat valid
- D_PLD_VALID  in  [Numports-1:0]  payload beat valid
- Q_BP  in  1  downstream backpressure
- GRANT  out  [Numports-1:0]  one-hot grant, 0 when idle
- SEL  out  [$clog2(Numports)-1:0]  binary index of granted port
- BUSY  out  1  frame in progress
- D_BP  out  [Numports-1:0]  backpressure to inputs
- COLLISION  out  1  one-cycle pulse
- TIMEOUT  out  1  one-cycle pulse
- ABORT  out  1  one-cycle pulse

Behaviour:
- Reset and clock: RST synchronous, active-high; clock CLK. Under reset, every register updates on the CLK edge.
- Reset values: GRANT=0, SEL=0, BUSY=0, COLLISION/TIMEOUT/ABORT=0, D_BP=0, pending=0, rr_ptr=0, wdog=0, state=IDLE.
- Request: req[i] = DEST_VALID[i] && DEST[i]==PortNo && D_SOF[i].
- Pending latch: pending[i] sets on req[i] when i is not granted. It clears when i is granted or DEST_VALID[i]==0.
- Candidate set: cand = req | pending.
- beat = (D_HDR_VALID[SEL] | D_PLD_VALID[SEL]) && !Q_BP.
- State IDLE: if cand != 0, pick the first set bit searching from rr_ptr upward with wrap mod Numports.
  - Next cycle: GRANT=onehot(pick), SEL=pick, BUSY=1, rr_ptr=(pick+1)%Numports, go to HOLD.
  - Latency: SOF cycle to GRANT is exactly 1 cycle, so GRANT aligns with the header beat.
- State HOLD, evaluated in priority order:
  - DEST_VALID[SEL]==0: ABORT pulse, go to IDLE.
  - beat && D_EOF[SEL]: go to IDLE.
  - wdog==2^TimeoutW-1: TIMEOUT pulse, go to IDLE.
  - wdog increments on non-beat cycles with Q_BP==0, clears on any beat, and holds while Q_BP==1.
- Leaving HOLD: GRANT=0, BUSY=0 in the following cycle. IDLE may re-grant in the cycle after that, giving a 1-cycle minimum inter-frame gap.
- COLLISION: registered pulse, one cycle after either condition:
  - popcount(cand)>=2 in IDLE, or
  - any req[i] for i!=SEL while in HOLD.
- D_BP (combinational from registered state plus Q_BP):
  - D_BP[SEL] = Q_BP when BUSY.
  - D_BP[i] = 1 for pending[i] and not granted.
  - All other bits 0.
- Simultaneous events:
  - EOF and a new SOF from another port in the same cycle: the new requester becomes pending, with no COLLISION.
  - EOF and ABORT in the same cycle: ABORT wins.
- Reset mid-frame: GRANT drops the cycle after RST is sampled; rr_ptr returns to 0.

Decomposition:
- Package routex_pkg: state enum (IDLE, HOLD); port index typedef; function onehot2bin.
- One sub-module, routex_rr_pick: combinational round-robin priority encoder with inputs cand and rr_ptr and outputs pick and valid. Reusable by other routex arbiters.

Test Plan (Numports=4, PortNo=1):
1. Ports 0 and 1 both assert DEST=1, DEST_VALID, SOF at cycle t.
   - Required at t+1: GRANT=4'b0001, SEL=0, COLLISION=1 for one cycle, D_BP=4'b0010.
   - Port 1 drops DEST_VALID at t+2: pending[1] clears and D_BP=0.
2. Port 0 frame: header at t+1, payload t+2..t+3, EOF with PLD_VALID at t+4.
   - Required: GRANT=0 and BUSY=0 at t+5.
3. Ports 0 and 1 keep DEST_VALID high with SOF together after reset.
   - Required: port 0 is granted first; after its EOF, port 1 is granted, since rr_ptr=1.
4. Port 2 sends SOF with DEST=2.
   - Required: no GRANT, no COLLISION, D_BP=0.
5. Q_BP=1 during port 0's EOF beat.
   - Required: GRANT is held and D_BP[0]=1; release occurs one cycle after Q_BP drops with EOF still asserted.
6. TimeoutW=4, granted port sends no beats with Q_BP=0.
   - Required: TIMEOUT pulse after 15 idle cycles, and GRANT=0 the following cycle.
   - Repeat with RST asserted mid-frame: GRANT=0 next cycle.

Source files
------------

// File: rtl/routex_pkg.sv
// Shared types and helpers for the routex arbitration blocks.
package routex_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Port number as carried on the DEST sideband
  typedef logic [7:0] port_id_t;

  function automatic logic [4:0] onehot2bin(input logic [31:0] oh);
    logic [4:0] bin;
    bin = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) bin = bin | 5'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/routex_rr_pick.sv
// Round-robin priority encoder: first set bit of cand at or above rr_ptr, wrapping.
// Purely combinational, no backpressure.
module routex_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         cand,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [$clog2(N)-1:0] pick,
  output logic                 valid
);

  always_comb begin
    int idx;
    pick  = '0;
    valid = |cand;
    idx   = 0;
    // Walk downward so the candidate closest to rr_ptr is written last and wins
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N;
      if (cand[idx]) pick = ($clog2(N))'(idx);
    end
  end

endmodule

// File: rtl/routex_port_arbiter.sv
// Grants one input the output port for a whole frame, round-robin; grant 1 cycle after SOF.
// Losers are held off via D_BP; the owner sees Q_BP on its D_BP bit.
module routex_port_arbiter
  import routex_pkg::*;
#(
  parameter int Numports = 4,
  parameter int PortNo   = 1,
  parameter int TimeoutW = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [Numports-1:0][7:0]    DEST,
  input  logic [Numports-1:0]         DEST_VALID,
  input  logic [Numports-1:0]         D_SOF,
  input  logic [Numports-1:0]         D_EOF,
  input  logic [Numports-1:0]         D_HDR_VALID,
  input  logic [Numports-1:0]         D_PLD_VALID,
  input  logic                        Q_BP,
  output logic [Numports-1:0]         GRANT,
  output logic [$clog2(Numports)-1:0] SEL,
  output logic                        BUSY,
  output logic [Numports-1:0]         D_BP,
  output logic                        COLLISION,
  output logic                        TIMEOUT,
  output logic                        ABORT
);

  localparam int SelW = $clog2(Numports);

  state_e                state_q, state_d;
  logic [Numports-1:0]   grant_q, grant_d;
  logic [Numports-1:0]   pending_q, pending_d;
  logic [Numports-1:0]   req, cand;
  logic [SelW-1:0]       rr_ptr_q, rr_ptr_d, pick;
  logic [TimeoutW-1:0]   wdog_q, wdog_d;
  logic                  pick_vld, beat;
  logic                  busy_q, busy_d;
  logic                  coll_q, coll_d, tmo_q, tmo_d, abort_q, abort_d;

  always_comb begin
    for (int i = 0; i < Numports; i++) begin
      req[i] = DEST_VALID[i] && (port_id_t'(DEST[i]) == port_id_t'(PortNo)) && D_SOF[i];
    end
  end

  assign cand = req | pending_q;
  assign SEL  = SelW'(onehot2bin(32'(grant_q)));
  assign beat = (D_HDR_VALID[SEL] | D_PLD_VALID[SEL]) & ~Q_BP;

  routex_rr_pick #(.N(Numports)) u_pick (
    .cand   (cand),
    .rr_ptr (rr_ptr_q),
    .pick   (pick),
    .valid  (pick_vld)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    rr_ptr_d  = rr_ptr_q;
    wdog_d    = wdog_q;
    coll_d    = 1'b0;
    tmo_d     = 1'b0;
    abort_d   = 1'b0;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        coll_d = $countones(cand) >= 2;
        if (pick_vld) begin
          grant_d  = Numports'(1) << pick;
          busy_d   = 1'b1;
          rr_ptr_d = (pick == SelW'(Numports - 1)) ? '0 : pick + 1'b1;
          wdog_d   = '0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        coll_d = |(req & ~grant_q);
        if (!DEST_VALID[SEL] || (beat && D_EOF[SEL]) || (&wdog_q)) begin
          grant_d = '0;
          busy_d  = 1'b0;
          wdog_d  = '0;
          state_d = IDLE;
        end else if (beat) begin
          wdog_d = '0;
        end else if (!Q_BP) begin
          wdog_d = wdog_q + 1'b1;
        end
        // Release reasons in priority order; an EOF hand-off is not a collision
        if (!DEST_VALID[SEL])          abort_d = 1'b1;
        else if (beat && D_EOF[SEL])   coll_d  = 1'b0;
        else if (&wdog_q)              tmo_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    for (int i = 0; i < Numports; i++) begin
      if (!DEST_VALID[i] || grant_d[i]) pending_d[i] = 1'b0;
      else if (req[i] && !grant_q[i])   pending_d[i] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      wdog_q    <= '0;
      coll_q    <= 1'b0;
      tmo_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      wdog_q    <= wdog_d;
      coll_q    <= coll_d;
      tmo_q     <= tmo_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    D_BP = pending_q & ~grant_q;
    if (busy_q) D_BP[SEL] = Q_BP;
  end

  assign GRANT     = grant_q;
  assign BUSY      = busy_q;
  assign COLLISION = coll_q;
  assign TIMEOUT   = tmo_q;
  assign ABORT     = abort_q;

endmodule
